// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the main-memory word port.
// Requester 0 is the datapath, requester 1 the loader/debug path; each access ends in a one-cycle ack.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_WORDS   = 512,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  // One extra bit so MEM_WORDS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(MEM_WORDS);
  localparam logic [3:0]      WAIT_LAST  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        wait_cnt;
  logic              last_grant;
  logic              sel;
  logic              err_flag;
  logic              rd_ok;
  logic              enter_done;
  logic              grant_vld;
  logic              grant_sel;
  logic              g_we;
  logic              g_in_range;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  always_comb begin
    grant_vld  = req0 | req1;
    grant_sel  = (req0 & req1) ? ~last_grant : req1;
    g_we       = grant_sel ? we1 : we0;
    g_addr     = grant_sel ? addr1 : addr0;
    g_wdata    = grant_sel ? wdata1 : wdata0;
    g_in_range = ({1'b0, g_addr} < ADDR_LIMIT);

    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = (WAIT_STATES > 0) ? WAIT : DONE;
      WAIT:    if (wait_cnt == WAIT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    enter_done = (state_nxt == DONE) && (state != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= 4'd0;
      last_grant <= 1'b1;
      sel        <= 1'b0;
      err_flag   <= 1'b0;
      rd_ok      <= 1'b0;
      mem_wen    <= 1'b0;
      mem_ren    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            sel        <= grant_sel;
            last_grant <= grant_sel;
            mem_addr   <= g_addr;
            mem_wdata  <= g_wdata;
            mem_wen    <= g_in_range & g_we;
            mem_ren    <= g_in_range & ~g_we;
            err_flag   <= ~g_in_range;
            rd_ok      <= g_in_range & ~g_we;
          end
        end
        ACCESS: begin
          mem_wen  <= 1'b0;
          mem_ren  <= 1'b0;
          wait_cnt <= 4'd0;
        end
        WAIT: wait_cnt <= wait_cnt + 4'd1;
        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
        default: ;
      endcase
      // Memory drove mem_rdata on the falling edge inside ACCESS; it is stable here.
      if (enter_done) begin
        rdata <= rd_ok ? mem_rdata : '0;
        err   <= err_flag;
        ack0  <= ~sel;
        ack1  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with no wait states, instance 1 with three,
// each attached to a falling-edge word memory model; acks are checked against a queue.
module tb_mem_port_arbiter;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 [2];
  logic        we0 [2];
  logic [31:0] addr0 [2];
  logic [31:0] wdata0 [2];
  logic        ack0 [2];
  logic        req1 [2];
  logic        we1 [2];
  logic [31:0] addr1 [2];
  logic [31:0] wdata1 [2];
  logic        ack1 [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic        mem_wen [2];
  logic        mem_ren [2];
  logic [31:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [31:0] mem [2][512];

  exp_t q0[$];
  exp_t q1[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(512), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .we0(we0[0]), .addr0(addr0[0]), .wdata0(wdata0[0]), .ack0(ack0[0]),
    .req1(req1[0]), .we1(we1[0]), .addr1(addr1[0]), .wdata1(wdata1[0]), .ack1(ack1[0]),
    .rdata(rdata[0]), .err(err[0]), .mem_wen(mem_wen[0]), .mem_ren(mem_ren[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(512), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .we0(we0[1]), .addr0(addr0[1]), .wdata0(wdata0[1]), .ack0(ack0[1]),
    .req1(req1[1]), .we1(we1[1]), .addr1(addr1[1]), .wdata1(wdata1[1]), .ack1(ack1[1]),
    .rdata(rdata[1]), .err(err[1]), .mem_wen(mem_wen[1]), .mem_ren(mem_ren[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Word memory: samples strobes and updates read data on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_wen[i]) mem[i][mem_addr[i][8:0]] <= mem_wdata[i];
      if (mem_ren[i]) mem_rdata[i] <= mem[i][mem_addr[i][8:0]];
    end
  end

  // Monitor: every ack pops the oldest expectation of its instance.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (mem_wen[i] || mem_ren[i])
          chk($sformatf("strobe_exclusive[%0d]", i), 32'(mem_wen[i] & mem_ren[i]), 32'd0);
        if (ack0[i] || ack1[i]) begin
          exp_t e;
          int   qsz;
          chk($sformatf("ack_onehot[%0d]", i), 32'(ack0[i] & ack1[i]), 32'd0);
          qsz = (i == 0) ? q0.size() : q1.size();
          chk($sformatf("ack_expected[%0d]", i), 32'(qsz > 0), 32'd1);
          if (qsz > 0) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("ack_id[%0d]", i), 32'(ack1[i]), 32'(e.id));
            chk($sformatf("rdata[%0d]", i), rdata[i], e.rdata);
            chk($sformatf("err[%0d]", i), 32'(err[i]), 32'(e.err));
          end
        end
      end
    end
  end

  task automatic drive(input int inst, input int id, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (id == 0) begin
      req0[inst] = req; we0[inst] = we; addr0[inst] = addr; wdata0[inst] = wdata;
    end else begin
      req1[inst] = req; we1[inst] = we; addr1[inst] = addr; wdata1[inst] = wdata;
    end
  endtask

  // Called at posedge+1 with the instance idle; the next edge samples the request.
  task automatic issue(input int inst, input int id, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    exp_t e;
    int   n;
    logic in_range;
    in_range = (addr < 32'd512);
    e.id = id; e.rdata = exp_rd; e.err = exp_err;
    if (inst == 0) q0.push_back(e);
    else           q1.push_back(e);
    drive(inst, id, 1'b1, we, addr, wdata);
    @(posedge clk); #1;
    chk("strobe_ren", 32'(mem_ren[inst]), 32'(!we && in_range));
    chk("strobe_wen", 32'(mem_wen[inst]), 32'(we && in_range));
    chk("strobe_addr", mem_addr[inst], addr);
    chk("strobe_wdata", mem_wdata[inst], wdata);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      chk("strobe_one_cycle", 32'(mem_ren[inst] | mem_wen[inst]), 32'd0);
    end while (!(ack0[inst] || ack1[inst]) && n < 40);
    chk("ack_latency", 32'(n), 32'(1 + ((inst == 1) ? 3 : 0)));
    drive(inst, id, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 512; a++) mem[i][a] = 32'h0;
      mem_rdata[i] = 32'h0;
      drive(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(i, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    mem[0][1] = 32'h11111111;
    mem[0][2] = 32'h22222222;
    mem[0][3] = 32'h00000033;
    mem[0][5] = 32'hDEADBEEF;
    mem[1][0] = 32'hCAFEF00D;

    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack0", 32'(ack0[i]), 32'd0);
      chk("rst_ack1", 32'(ack1[i]), 32'd0);
      chk("rst_err", 32'(err[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_strobes", 32'({mem_wen[i], mem_ren[i]}), 32'd0);
      chk("rst_mem_addr", mem_addr[i], 32'd0);
      chk("rst_mem_wdata", mem_wdata[i], 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    issue(0, 0, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF, 1'b0);
    issue(0, 1, 1'b1, 32'd7, 32'h12345678, 32'h0, 1'b0);
    chk("mem_word7", mem[0][7], 32'h12345678);
    issue(0, 1, 1'b0, 32'd7, 32'd0, 32'h12345678, 1'b0);
    issue(0, 0, 1'b0, 32'd512, 32'd0, 32'h0, 1'b1);

    // Both requesters held from reset: grants alternate starting with requester 0.
    rst = 1'b1;
    drive(0, 0, 1'b1, 1'b0, 32'd1, 32'd0);
    drive(0, 1, 1'b1, 1'b0, 32'd2, 32'd0);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.id = 0; e.rdata = 32'h11111111; e.err = 1'b0; q0.push_back(e);
      e.id = 1; e.rdata = 32'h22222222; e.err = 1'b0; q0.push_back(e);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!(ack0[0] || ack1[0]) && n < 20);
      chk("rr_period", 32'(n), 32'((k == 0) ? 2 : 3));
      chk("rr_grant", 32'(ack1[0]), 32'(k % 2));
    end
    drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    issue(1, 0, 1'b0, 32'd0, 32'd0, 32'hCAFEF00D, 1'b0);
    issue(1, 1, 1'b1, 32'd1000, 32'h55, 32'h0, 1'b1);

    // Reset during the ACCESS cycle, ahead of the falling edge, aborts the write.
    drive(0, 0, 1'b1, 1'b1, 32'd3, 32'hAA);
    @(posedge clk); #1;
    chk("abort_wen_before", 32'(mem_wen[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_wen_after", 32'(mem_wen[0]), 32'd0);
    chk("abort_mem_addr", mem_addr[0], 32'd0);
    drive(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_ack", 32'({ack0[0], ack1[0]}), 32'd0);
    chk("abort_word3", mem[0][3], 32'h00000033);
    issue(0, 0, 1'b0, 32'd3, 32'd0, 32'h00000033, 1'b0);

    repeat (2) @(posedge clk);
    chk("pending_acks", 32'(q0.size() + q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the read/write word port (port A) of main memory.
- Requester 0 is the MIC-1 datapath (MAR/MDR word access); requester 1 is the program loader/debug access.
- Grants the port round-robin, drives one-cycle registered read/write strobes, waits a configurable number of wait states, then captures read data and returns a one-cycle acknowledge.
- Out-of-range addresses are rejected without touching memory.

Parameters:
- ADDR_W, 32, width of word addresses on requester and memory sides.
- DATA_W, 32, data word width.
- MEM_WORDS, 512, number of valid words; addresses >= MEM_WORDS are errors.
- WAIT_STATES, 0, extra cycles between strobe and capture (0..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 access request; held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same definitions for requester 1.
- rdata  out  DATA_W  read data; valid only while ack0 or ack1 is high.
- err  out  1  high with ack when the access was out of range.
- mem_wen  out  1  memory write strobe, registered.
- mem_ren  out  1  memory read strobe, registered.
- mem_addr  out  ADDR_W  memory word address, registered.
- mem_wdata  out  DATA_W  memory write data, registered.
- mem_rdata  in  DATA_W  memory read data; updated by memory on falling clk edge.

Behaviour:
- Reset values: all outputs 0; state IDLE; wait counter 0; last_grant = 1, so requester 0 wins the first contest.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - Samples req0/req1 on the rising edge.
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the requester that is not last_grant.
  - On grant: latch sel, we, addr, wdata; update last_grant; go to ACCESS.
- Strobe register timing: on the IDLE->ACCESS edge, mem_addr and mem_wdata load from the granted requester. If addr < MEM_WORDS, mem_wen = we and mem_ren = !we; otherwise both stay 0 and an internal err flag is set.
- ACCESS:
  - Strobes are high for exactly this one cycle; the memory samples them on the falling edge inside it.
  - On exit, strobes clear to 0; mem_addr and mem_wdata hold their values.
  - Next state is WAIT if WAIT_STATES > 0, else DONE.
- WAIT: counts WAIT_STATES cycles, then goes to DONE. The counter is cleared on entry.
- DONE entry edge:
  - rdata <= mem_rdata for an in-range read; otherwise rdata <= 0.
  - err <= err flag.
  - ack of the granted requester <= 1.
- DONE lasts exactly one cycle, then goes to IDLE; ack, err and rdata clear to 0 on exit.
- Latency: with req sampled at edge t0, the strobe is visible t0..t1 and ack is high during cycle (t1+WAIT_STATES)..(t2+WAIT_STATES).
- Throughput: one access per 3+WAIT_STATES cycles.
- Requests are sampled only in IDLE. A requester must drop req after seeing ack; a req still high in IDLE after DONE is a new access.
- req, we, addr and wdata changes outside IDLE are ignored, since the values were latched at grant.
- The non-granted requester waits. Round-robin guarantees it is served next, so neither requester starves.
- Out-of-range access:
  - No memory strobe.
  - ack asserts with err = 1 and rdata = 0.
  - Same latency as an in-range access.
- rst mid-operation:
  - Immediately forces state IDLE and all outputs 0.
  - If asserted during ACCESS before the falling edge, the memory access is suppressed.
  - No ack is produced for an aborted access.
- Exactly one of ack0/ack1 can be high in any cycle. mem_wen and mem_ren are never high together.

Test Plan:
- WAIT_STATES=0, memory preloaded word 5 = 0xDEADBEEF; req0 read addr 5 -> mem_ren high one cycle with mem_addr=5; ack0 one cycle later with rdata=0xDEADBEEF, err=0.
- req1 write addr 7 data 0x12345678, then req1 read addr 7 -> mem_wen high one cycle with mem_wdata=0x12345678; the read acks with rdata=0x12345678.
- req0 and req1 held continuously from reset, reading addrs 1 and 2 -> grants alternate 0,1,0,1; ack0 rdata=word1, ack1 rdata=word2; one access every 3 cycles.
- req0 read addr 512 (MEM_WORDS=512) -> mem_ren and mem_wen stay 0; ack0 with err=1, rdata=0.
- WAIT_STATES=3; req0 read addr 0 -> ack0 exactly 4 cycles after the strobe cycle begins; mem_ren high only 1 cycle.
- req0 write addr 3 data 0xAA; assert rst in the ACCESS cycle before the falling clk edge -> mem_wen falls immediately; word 3 is unchanged; no ack0; state IDLE after rst release; next req0 is served normally.
